// File: rtl/display_pkg.sv
// Shared types and the display memory entry format for the display write arbiter.
package display_pkg;

   localparam int unsigned DIGITS = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DIN_W  = 6;

   // Entry layout: [5]=segment enable (not blank), [4:1]=digit, [0]=dp off (active-low dp)
   localparam int unsigned DIN_BLANK_N   = 5;
   localparam int unsigned DIN_DIGIT_LSB = 1;
   localparam int unsigned DIN_DP_N      = 0;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StDone
   } state_e;

   function automatic logic [DIN_W-1:0] pack_din(input logic       blank,
                                                 input logic [3:0] digit,
                                                 input logic       dp);
      logic [DIN_W-1:0] din;
      din                         = '0;
      din[DIN_BLANK_N]            = ~blank;
      din[DIN_DIGIT_LSB +: 4]     = digit;
      din[DIN_DP_N]               = ~dp;
      return din;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last granted requester.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last_grant,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      grant_idx,
   output logic            valid
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      // k is the rotation distance from last_grant; the first requesting index wins
      for (int k = 1; k <= int'(NREQ); k++) begin
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!valid && req[j] && (((int'(last_grant) + k) % int'(NREQ)) == j)) begin
               valid     = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = 2'(j);
            end
         end
      end
   end

endmodule

// File: rtl/display_write_arbiter.sv
// Round-robin arbiter that latches one producer's 8-digit frame and writes it to the
// seven-segment display memory, address 7 down to 0.
module display_write_arbiter
   import display_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*4*DIGITS-1:0]   frame,
   input  logic [NREQ*DIGITS-1:0]     blank,
   input  logic [NREQ*DIGITS-1:0]     dp,
   output logic [NREQ-1:0]            ack,
   output logic [1:0]                 owner,
   output logic                       busy,
   output logic                       done,
   output logic                       W,
   output logic [ADDR_W-1:0]          WADD,
   output logic [DIN_W-1:0]           DIN
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wadd_q, wadd_d;
   logic                w_q, w_d;
   logic [DIN_W-1:0]    din_q, din_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [1:0]          owner_q, owner_d;
   logic [1:0]          last_q, last_d;
   logic [4*DIGITS-1:0] frame_q, frame_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic [DIGITS-1:0]   dp_q, dp_d;

   logic [NREQ-1:0]     grant;
   logic [1:0]          grant_idx;
   logic                grant_valid;
   logic [4*DIGITS-1:0] win_frame;
   logic [DIGITS-1:0]   win_blank;
   logic [DIGITS-1:0]   win_dp;
   logic [ADDR_W-1:0]   nxt_addr;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req        (req),
      .last_grant (last_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .valid      (grant_valid)
   );

   always_comb begin
      win_frame = '0;
      win_blank = '0;
      win_dp    = '0;
      for (int j = 0; j < int'(NREQ); j++) begin
         if (grant[j]) begin
            win_frame = frame[j*4*DIGITS +: 4*DIGITS];
            win_blank = blank[j*DIGITS +: DIGITS];
            win_dp    = dp[j*DIGITS +: DIGITS];
         end
      end
   end

   assign nxt_addr = wadd_q - 1'b1;

   always_comb begin
      state_d = state_q;
      wadd_d  = wadd_q;
      w_d     = 1'b0;
      din_d   = din_q;
      ack_d   = '0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      owner_d = owner_q;
      last_d  = last_q;
      frame_d = frame_q;
      blank_d = blank_q;
      dp_d    = dp_q;
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (grant_valid) begin
               // First write is issued straight from the winner's inputs so it lands with ack
               state_d = StWrite;
               frame_d = win_frame;
               blank_d = win_blank;
               dp_d    = win_dp;
               ack_d   = grant;
               owner_d = grant_idx;
               last_d  = grant_idx;
               busy_d  = 1'b1;
               w_d     = 1'b1;
               wadd_d  = ADDR_W'(DIGITS - 1);
               din_d   = pack_din(win_blank[DIGITS-1], win_frame[4*DIGITS-1 -: 4],
                                  win_dp[DIGITS-1]);
            end
         end
         StWrite: begin
            busy_d = 1'b1;
            if (wadd_q == '0) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               w_d    = 1'b1;
               wadd_d = nxt_addr;
               din_d  = pack_din(blank_q[nxt_addr], frame_q[{nxt_addr, 2'b00} +: 4],
                                 dp_q[nxt_addr]);
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wadd_q  <= '0;
         w_q     <= 1'b0;
         din_q   <= '0;
         ack_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         owner_q <= '0;
         last_q  <= 2'(NREQ - 1);
         frame_q <= '0;
         blank_q <= '0;
         dp_q    <= '0;
      end else begin
         state_q <= state_d;
         wadd_q  <= wadd_d;
         w_q     <= w_d;
         din_q   <= din_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         frame_q <= frame_d;
         blank_q <= blank_d;
         dp_q    <= dp_d;
      end
   end

   assign ack   = ack_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign W     = w_q;
   assign WADD  = wadd_q;
   assign DIN   = din_q;

endmodule

// File: tb/tb_display_write_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and write data at each
// sampling edge; a monitor checks the DUT's write port against the queued frames.
module tb_display_write_arbiter;

   localparam int unsigned NREQ = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req;
   logic [NREQ*32-1:0]   frame;
   logic [NREQ*8-1:0]    blank;
   logic [NREQ*8-1:0]    dp;
   logic [NREQ-1:0]      ack;
   logic [1:0]           owner;
   logic                 busy;
   logic                 done;
   logic                 W;
   logic [2:0]           WADD;
   logic [5:0]           DIN;

   display_write_arbiter #(
      .NREQ (NREQ)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .frame (frame),
      .blank (blank),
      .dp    (dp),
      .ack   (ack),
      .owner (owner),
      .busy  (busy),
      .done  (done),
      .W     (W),
      .WADD  (WADD),
      .DIN   (DIN)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edge_no;
      int          winner;
      logic [47:0] dins;
   } exp_t;

   exp_t            exp_q[$];
   exp_t            cur;
   bit              cur_active = 0;
   int              wcount = 0;
   int              checks = 0;
   int              errors = 0;
   int              ecount = 0;
   int              next_free = 0;
   int              last_g = NREQ - 1;
   int              exp_owner = 0;
   int              busy_lo = 1;
   int              busy_hi = 0;
   int              grant_log[$];
   logic [5:0]      seen_din [8];
   bit              rand_data = 0;
   bit              fair_mode = 0;
   logic [NREQ-1:0] rereq = '0;
   logic [NREQ-1:0] acked_now = '0;
   int              w;
   exp_t            e;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [5:0] ref_din(input logic b, input logic [3:0] d, input logic p);
      return {~b, d, ~p};
   endfunction

   // Reference model: at each edge, if the previous frame's 10-cycle slot has elapsed,
   // the first requester after the last grant (cyclically) wins and its data is captured.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_g    = NREQ - 1;
         next_free = 0;
         exp_owner = 0;
         busy_lo   = 1;
         busy_hi   = 0;
         exp_q.delete();
      end else begin
         ecount++;
         if (ecount >= next_free && req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               if (w < 0 && req[(last_g + k) % NREQ]) w = (last_g + k) % NREQ;
            end
            e.edge_no = ecount;
            e.winner  = w;
            for (int a = 0; a < 8; a++) begin
               e.dins[a*6 +: 6] = ref_din(blank[w*8 + a], frame[w*32 + a*4 +: 4], dp[w*8 + a]);
            end
            exp_q.push_back(e);
            last_g    = w;
            exp_owner = w;
            next_free = ecount + 10;
            busy_lo   = ecount;
            busy_hi   = ecount + 8;
         end
      end
   end

   // Monitor: outputs change only on posedge, so sample at negedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_active = 0;
         wcount     = 0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].edge_no == ecount) begin
            cur = exp_q.pop_front();
            check("ack", 64'(ack), 64'(1) << cur.winner);
            grant_log.push_back(int'(owner));
            cur_active = 1;
            wcount     = 0;
         end else begin
            check("ack_unexpected", 64'(ack), 64'(0));
         end
         if (cur_active && wcount < 8) begin
            check("W", 64'(W), 64'(1));
            check("WADD", 64'(WADD), 64'(7 - wcount));
            check("DIN", 64'(DIN), 64'(cur.dins[(7 - wcount)*6 +: 6]));
            seen_din[WADD] = DIN;
            wcount++;
         end else if (cur_active) begin
            check("done", 64'(done), 64'(1));
            check("W_in_done", 64'(W), 64'(0));
            cur_active = 0;
         end else begin
            check("W_idle", 64'(W), 64'(0));
            check("done_idle", 64'(done), 64'(0));
         end
         check("busy", 64'(busy), 64'(ecount >= busy_lo && ecount <= busy_hi));
         check("owner", 64'(owner), 64'(exp_owner));
      end
   end

   task automatic step();
      @(negedge clk);
      acked_now = ack;
      for (int i = 0; i < NREQ; i++) begin
         if (rereq[i]) begin
            req[i]   = 1'b1;
            rereq[i] = 1'b0;
         end
         if (ack[i]) begin
            req[i] = 1'b0;
            if (fair_mode && i == 1) rereq[i] = 1'b1;
         end
      end
      if (rand_data) begin
         frame = {$urandom, $urandom};
         blank = 16'($urandom);
         dp    = 16'($urandom);
      end
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      do begin
         step();
         n++;
      end while (done !== 1'b1 && n < bound);
      if (done !== 1'b1) check("done_timeout", 64'(done), 64'(1));
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      step();
      step();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int n;
      req   = '0;
      frame = '0;
      blank = '0;
      dp    = '0;
      repeat (3) @(negedge clk);
      check("rst_W", 64'(W), 64'(0));
      check("rst_WADD", 64'(WADD), 64'(0));
      check("rst_DIN", 64'(DIN), 64'(0));
      check("rst_ack", 64'(ack), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_owner", 64'(owner), 64'(0));
      #1 rst_n = 1'b1;

      // Single frame with known digits
      for (int a = 0; a < 8; a++) seen_din[a] = '0;
      frame[31:0] = 32'h7654_3210;
      req[0]      = 1'b1;
      wait_done(20);
      for (int a = 0; a < 8; a++) check("single_din", 64'(seen_din[a]), 64'(6'h21 + 2*a));

      // Blank and decimal point placement
      step();
      frame[31:0] = 32'h9000_0005;
      blank[7:0]  = 8'h80;
      dp[7:0]     = 8'h01;
      req[0]      = 1'b1;
      wait_done(20);
      check("blank_addr7", 64'(seen_din[7]), 64'(6'h13));
      check("dp_addr0", 64'(seen_din[0]), 64'(6'h2A));

      // Contention from reset: 0 first, then 1
      do_reset();
      grant_log.delete();
      req = 2'b11;
      wait_done(20);
      wait_done(20);
      check("cont_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
      check("cont_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(1));

      // Fairness: requester 1 re-requests constantly, requester 0 once mid-frame
      step();
      grant_log.delete();
      fair_mode = 1;
      req[1]    = 1'b1;
      n = 0;
      do begin step(); n++; end while (!acked_now[1] && n < 20);
      repeat (3) step();
      req[0] = 1'b1;
      wait_done(20);
      wait_done(20);
      wait_done(20);
      fair_mode = 0;
      wait_done(20);
      check("fair_0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));
      check("fair_1", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(0));
      check("fair_2", 64'(grant_log.size() > 2 ? grant_log[2] : -1), 64'(1));

      // Asynchronous reset in the middle of a frame
      repeat (2) step();
      req[0] = 1'b1;
      n = 0;
      do begin step(); n++; end while (!(W === 1'b1 && WADD === 3'd4) && n < 20);
      check("reach_wadd4", 64'(WADD), 64'(4));
      #2 rst_n = 1'b0;
      #1;
      check("arst_W", 64'(W), 64'(0));
      check("arst_WADD", 64'(WADD), 64'(0));
      check("arst_DIN", 64'(DIN), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_ack", 64'(ack), 64'(0));
      repeat (2) step();
      #1 rst_n = 1'b1;
      repeat (3) step();
      grant_log.delete();
      req = 2'b11;
      wait_done(20);
      wait_done(20);
      check("post_rst_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

      // Random traffic with data changing every cycle
      rand_data = 1;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (!acked_now[i]) begin
               if (!req[i] && $urandom_range(7) == 0) req[i] = 1'b1;
               else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
            end
         end
      end
      req = '0;
      repeat (15) step();
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
